// File: rtl/i2c_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder_if
// Description : User-side and SCL/enable signals of the I2C responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_responder_if;
   logic       EN;
   logic       SCL;
   logic [7:0] TxData;
   logic       TxLoad;
   logic [7:0] RxData;
   logic       RxValid;
   logic       Busy;
   logic       DoneFlag;

   modport slave (
      input  EN, SCL, TxData,
      output TxLoad, RxData, RxValid, Busy, DoneFlag
   );

   modport master (
      output EN, SCL, TxData,
      input  TxLoad, RxData, RxValid, Busy, DoneFlag
   );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder
// Description : Fixed-address I2C target, oversampled SCL/SDA, no clock stretch.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
   input  wire                          CLK_IN,
   input  wire                          RST_IN,
   inout  wire                          SDA,
   i2c_slave_responder_if.slave         bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ADDR_ACK  = 3'd2,
      S_WR_BYTE   = 3'd3,
      S_WR_ACK    = 3'd4,
      S_RD_BYTE   = 3'd5,
      S_RD_ACK    = 3'd6,
      S_WAIT_STOP = 3'd7
   } state_t;

   state_t     state_q;
   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_prev_q, sda_prev_q;
   logic [2:0] bit_cnt_q;
   logic       byte_full_q;
   logic [7:0] shift_q;
   logic [7:0] rx_data_q;
   logic       rw_q, nack_q, addressed_q;
   logic       sda_low_q;
   logic       tx_load_q, rx_valid_q, busy_q, done_q;

   logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] shift_d;
   logic [2:0] bit_cnt_d;

   assign w_scl      = scl_sync_q[1];
   assign w_sda      = sda_sync_q[1];
   assign w_scl_rise = w_scl & ~scl_prev_q;
   assign w_scl_fall = ~w_scl & scl_prev_q;
   assign w_start    = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
   assign w_stop     = w_scl & scl_prev_q & ~sda_prev_q & w_sda;
   assign shift_d    = {shift_q[6:0], w_sda};
   assign bit_cnt_d  = bit_cnt_q + 3'd1;

   assign SDA          = sda_low_q ? 1'b0 : 1'bz;
   assign bus.TxLoad   = tx_load_q;
   assign bus.RxData   = rx_data_q;
   assign bus.RxValid  = rx_valid_q;
   assign bus.Busy     = busy_q;
   assign bus.DoneFlag = done_q;

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_q     <= S_IDLE;
         scl_sync_q  <= 2'b11;
         sda_sync_q  <= 2'b11;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         bit_cnt_q   <= 3'd0;
         byte_full_q <= 1'b0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rw_q        <= 1'b0;
         nack_q      <= 1'b0;
         addressed_q <= 1'b0;
         sda_low_q   <= 1'b0;
         tx_load_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], bus.SCL};
         sda_sync_q <= {sda_sync_q[0], SDA};
         scl_prev_q <= w_scl;
         sda_prev_q <= w_sda;
         tx_load_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;

         if (!bus.EN) begin
            state_q     <= S_IDLE;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_full_q <= 1'b0;
         end else if (w_stop) begin
            // addressed_q survives a NACK exit so the closing STOP still reports done
            state_q     <= S_IDLE;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            done_q      <= addressed_q;
         end else if (w_start) begin
            state_q     <= S_ADDR;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_full_q <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR, S_WR_BYTE: begin
                  if (w_scl_rise) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_d;
                     if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
                  end else if (w_scl_fall && byte_full_q) begin
                     byte_full_q <= 1'b0;
                     if (state_q == S_WR_BYTE) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        sda_low_q  <= 1'b1;
                        state_q    <= S_WR_ACK;
                     end else if (shift_q[7:1] == SLAVE_ADDR) begin
                        rw_q        <= shift_q[0];
                        sda_low_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        addressed_q <= 1'b1;
                        state_q     <= S_ADDR_ACK;
                     end else begin
                        state_q <= S_WAIT_STOP;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (rw_q) begin
                        tx_load_q <= 1'b1;
                        shift_q   <= bus.TxData;
                        sda_low_q <= ~bus.TxData[7];
                        bit_cnt_q <= 3'd0;
                        state_q   <= S_RD_BYTE;
                     end else begin
                        sda_low_q <= 1'b0;
                        state_q   <= S_WR_BYTE;
                     end
                  end
               end
               S_WR_ACK: begin
                  if (w_scl_fall) begin
                     sda_low_q <= 1'b0;
                     state_q   <= S_WR_BYTE;
                  end
               end
               S_RD_BYTE: begin
                  if (w_scl_fall) begin
                     if (bit_cnt_q == 3'd7) begin
                        sda_low_q <= 1'b0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= S_RD_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_d;
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_low_q <= ~shift_q[6];
                     end
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     nack_q <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!nack_q) begin
                        tx_load_q <= 1'b1;
                        shift_q   <= bus.TxData;
                        sda_low_q <= ~bus.TxData[7];
                        bit_cnt_q <= 3'd0;
                        state_q   <= S_RD_BYTE;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_WAIT_STOP;
                     end
                  end
               end
               S_WAIT_STOP: sda_low_q <= 1'b0;
               default:     state_q   <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_responder
// Description : Bit-banged I2C master with transaction-level expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;

   localparam int         Q       = 10;
   localparam logic [6:0] C_ADDR  = 7'h55;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_sda_low = 1'b0;
   wire  SDA;

   int n_cmp = 0, n_bad = 0;
   int rxv_cnt = 0, txl_cnt = 0, done_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;
   logic [7:0] model_rx = 8'h00;

   always #5 clk = ~clk;

   assign SDA = m_sda_low ? 1'b0 : 1'bz;
   pullup (SDA);

   i2c_slave_responder_if bus ();

   i2c_slave_responder #(.SLAVE_ADDR(C_ADDR)) dut (
      .CLK_IN (clk),
      .RST_IN (rst),
      .SDA    (SDA),
      .bus    (bus)
   );

   always @(negedge clk) begin
      if (bus.RxValid === 1'b1)  rxv_cnt++;
      if (bus.TxLoad === 1'b1)   txl_cnt++;
      if (bus.DoneFlag === 1'b1) done_cnt++;
      if (bus.Busy === 1'b1)     busy_cnt++;
      if (SDA === 1'b0 && !m_sda_low) dut_low_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_start();
      m_sda_low = 1'b0; cyc(Q);
      bus.SCL = 1'b1;   cyc(Q);
      m_sda_low = 1'b1; cyc(Q);
      bus.SCL = 1'b0;   cyc(Q);
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1; cyc(Q);
      bus.SCL = 1'b1;   cyc(Q);
      m_sda_low = 1'b0; cyc(2 * Q);
   endtask

   // one SCL period; b=1 releases SDA so the sampled value is whatever the bus holds
   task automatic m_bit(input logic b, output logic s);
      m_sda_low = ~b; cyc(Q);
      bus.SCL = 1'b1; cyc(Q);
      s = SDA;        cyc(Q);
      bus.SCL = 1'b0; cyc(Q);
   endtask

   task automatic m_write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(d[i], s);
      m_bit(1'b1, ack);
   endtask

   task automatic m_read_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         m_bit(1'b1, s);
         d = {d[6:0], s};
      end
      m_bit(m_ack, s);
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc(3);
      rst = 1'b0; cyc(5);
      n_cmp++; if (bus.TxLoad !== 1'b0) begin n_bad++; $display("FAIL reset_txload got %b want 0", bus.TxLoad); end
      n_cmp++; if (bus.RxValid !== 1'b0) begin n_bad++; $display("FAIL reset_rxvalid got %b want 0", bus.RxValid); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
      n_cmp++; if (bus.DoneFlag !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.DoneFlag); end
      n_cmp++; if (bus.RxData !== 8'h00) begin n_bad++; $display("FAIL reset_rxdata got %h want 00", bus.RxData); end
      n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL reset_sda got %b want 1", SDA); end
      model_rx = 8'h00;
   endtask

   task automatic test_write();
      int rv0, dn0;
      logic a0, a1;
      rv0 = rxv_cnt; dn0 = done_cnt;
      m_start();
      m_write_byte({C_ADDR, 1'b0}, a0);
      n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL write_busy got %b want 1", bus.Busy); end
      m_write_byte(8'hCA, a1);
      m_stop();
      model_rx = 8'hCA;
      n_cmp++; if (a0 !== 1'b0) begin n_bad++; $display("FAIL write_addr_ack got %b want 0", a0); end
      n_cmp++; if (a1 !== 1'b0) begin n_bad++; $display("FAIL write_data_ack got %b want 0", a1); end
      n_cmp++; if (bus.RxData !== model_rx) begin n_bad++; $display("FAIL write_rxdata got %h want %h", bus.RxData, model_rx); end
      n_cmp++; if (rxv_cnt - rv0 !== 1) begin n_bad++; $display("FAIL write_rxvalid got %0d want 1", rxv_cnt - rv0); end
      n_cmp++; if (done_cnt - dn0 !== 1) begin n_bad++; $display("FAIL write_done got %0d want 1", done_cnt - dn0); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_end got %b want 0", bus.Busy); end
   endtask

   task automatic test_wrong_addr();
      int rv0, tl0, dl0, bz0, dn0;
      logic a0, a1;
      rv0 = rxv_cnt; tl0 = txl_cnt; dl0 = dut_low_cnt; bz0 = busy_cnt; dn0 = done_cnt;
      m_start();
      m_write_byte({7'h2A, 1'b0}, a0);
      m_write_byte(8'h00, a1);
      m_stop();
      n_cmp++; if (a0 !== 1'b1) begin n_bad++; $display("FAIL wrong_addr_ack got %b want 1", a0); end
      n_cmp++; if (dut_low_cnt - dl0 !== 0) begin n_bad++; $display("FAIL wrong_sda_low got %0d want 0", dut_low_cnt - dl0); end
      n_cmp++; if ((rxv_cnt - rv0) + (txl_cnt - tl0) !== 0) begin n_bad++; $display("FAIL wrong_pulses got %0d want 0", (rxv_cnt - rv0) + (txl_cnt - tl0)); end
      n_cmp++; if (busy_cnt - bz0 !== 0) begin n_bad++; $display("FAIL wrong_busy got %0d want 0", busy_cnt - bz0); end
      n_cmp++; if (done_cnt - dn0 !== 0) begin n_bad++; $display("FAIL wrong_done got %0d want 0", done_cnt - dn0); end
   endtask

   task automatic test_read_nack();
      int tl0, dn0;
      logic a0;
      logic [7:0] d;
      tl0 = txl_cnt; dn0 = done_cnt;
      bus.TxData = 8'hA5;
      m_start();
      m_write_byte({C_ADDR, 1'b1}, a0);
      bus.TxData = 8'h00;
      m_read_byte(1'b1, d);
      n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL read_data got %h want a5", d); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL read_nack_busy got %b want 0", bus.Busy); end
      n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL read_nack_sda got %b want 1", SDA); end
      m_stop();
      n_cmp++; if (a0 !== 1'b0) begin n_bad++; $display("FAIL read_addr_ack got %b want 0", a0); end
      n_cmp++; if (txl_cnt - tl0 !== 1) begin n_bad++; $display("FAIL read_txload got %0d want 1", txl_cnt - tl0); end
      n_cmp++; if (done_cnt - dn0 !== 1) begin n_bad++; $display("FAIL read_done got %0d want 1", done_cnt - dn0); end
   endtask

   task automatic test_two_byte_read();
      int tl0;
      logic a0;
      logic [7:0] t0, t1, d0, d1;
      t0 = 8'($urandom); t1 = ~t0 ^ 8'($urandom_range(0, 15));
      tl0 = txl_cnt;
      bus.TxData = t0;
      m_start();
      m_write_byte({C_ADDR, 1'b1}, a0);
      bus.TxData = t1;
      m_read_byte(1'b0, d0);
      bus.TxData = 8'($urandom);
      m_read_byte(1'b1, d1);
      m_stop();
      n_cmp++; if (d0 !== t0) begin n_bad++; $display("FAIL read2_byte0 got %h want %h", d0, t0); end
      n_cmp++; if (d1 !== t1) begin n_bad++; $display("FAIL read2_byte1 got %h want %h", d1, t1); end
      n_cmp++; if (txl_cnt - tl0 !== 2) begin n_bad++; $display("FAIL read2_txload got %0d want 2", txl_cnt - tl0); end
   endtask

   task automatic test_rep_start();
      int rv0, dn0;
      logic a0, a1, a2;
      logic [7:0] d, t;
      rv0 = rxv_cnt; dn0 = done_cnt; t = 8'($urandom);
      m_start();
      m_write_byte({C_ADDR, 1'b0}, a0);
      m_write_byte(8'h11, a1);
      model_rx = 8'h11;
      bus.TxData = t;
      m_start();
      m_write_byte({C_ADDR, 1'b1}, a2);
      m_read_byte(1'b1, d);
      n_cmp++; if (done_cnt - dn0 !== 0) begin n_bad++; $display("FAIL rs_done_early got %0d want 0", done_cnt - dn0); end
      m_stop();
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL rs_acks got %b want 000", {a0, a1, a2}); end
      n_cmp++; if (d !== t) begin n_bad++; $display("FAIL rs_read got %h want %h", d, t); end
      n_cmp++; if (rxv_cnt - rv0 !== 1) begin n_bad++; $display("FAIL rs_rxvalid got %0d want 1", rxv_cnt - rv0); end
      n_cmp++; if (bus.RxData !== model_rx) begin n_bad++; $display("FAIL rs_rxdata got %h want %h", bus.RxData, model_rx); end
      n_cmp++; if (done_cnt - dn0 !== 1) begin n_bad++; $display("FAIL rs_done got %0d want 1", done_cnt - dn0); end
   endtask

   task automatic test_reset_mid();
      int rv0;
      logic a0, s;
      logic [7:0] b;
      // reset while the responder holds the address ACK low
      m_start();
      for (int i = 7; i >= 0; i--) begin b = {C_ADDR, 1'b0}; m_bit(b[i], s); end
      m_sda_low = 1'b0; cyc(Q);
      bus.SCL = 1'b1; cyc(Q);
      n_cmp++; if (SDA !== 1'b0) begin n_bad++; $display("FAIL rm_ack_driven got %b want 0", SDA); end
      rst = 1'b1; #1;
      n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL rm_sda_release got %b want 1", SDA); end
      cyc(2); rst = 1'b0; cyc(Q);
      bus.SCL = 1'b0; cyc(Q);
      m_stop();
      // reset during the 5th data bit of a write
      m_start();
      m_write_byte({C_ADDR, 1'b0}, a0);
      m_write_byte(8'h5A, a0);
      b = 8'hF8;
      for (int i = 7; i >= 4; i--) m_bit(b[i], s);
      m_sda_low = ~b[3]; cyc(2);
      rst = 1'b1; #1;
      model_rx = 8'h00;
      n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL rm_bit5_sda got %b want 1", SDA); end
      n_cmp++; if ({bus.Busy, bus.RxData} !== {1'b0, model_rx}) begin n_bad++; $display("FAIL rm_outputs got %h want %h", {bus.Busy, bus.RxData}, {1'b0, model_rx}); end
      cyc(2); rst = 1'b0; cyc(Q);
      m_stop();
      rv0 = rxv_cnt;
      m_start();
      m_write_byte({C_ADDR, 1'b0}, a0);
      m_write_byte(8'h3C, s);
      m_stop();
      model_rx = 8'h3C;
      n_cmp++; if ({a0, s} !== 2'b00) begin n_bad++; $display("FAIL rm_rejoin_acks got %b want 00", {a0, s}); end
      n_cmp++; if (bus.RxData !== model_rx) begin n_bad++; $display("FAIL rm_rejoin_rx got %h want %h", bus.RxData, model_rx); end
      n_cmp++; if (rxv_cnt - rv0 !== 1) begin n_bad++; $display("FAIL rm_rejoin_rxv got %0d want 1", rxv_cnt - rv0); end
   endtask

   task automatic test_enable();
      int dn0;
      logic a0, a1;
      logic [7:0] b;
      b = 8'($urandom); dn0 = done_cnt;
      m_start();
      m_write_byte({C_ADDR, 1'b0}, a0);
      m_write_byte(b, a1);
      model_rx = b;
      bus.EN = 1'b0; cyc(2);
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL en_busy got %b want 0", bus.Busy); end
      n_cmp++; if (bus.RxData !== model_rx) begin n_bad++; $display("FAIL en_rxdata got %h want %h", bus.RxData, model_rx); end
      n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL en_sda got %b want 1", SDA); end
      bus.EN = 1'b1; cyc(2);
      m_stop();
      n_cmp++; if (done_cnt - dn0 !== 0) begin n_bad++; $display("FAIL en_done got %0d want 0", done_cnt - dn0); end
   endtask

   task automatic test_random();
      logic [6:0] addr;
      logic       rw, hit, a, ack_m;
      logic [7:0] bytes[$];
      logic [7:0] d;
      int n, rv0, tl0, dn0;
      for (int it = 0; it < 8; it++) begin
         addr = $urandom_range(0, 1) ? C_ADDR : 7'($urandom_range(0, 127));
         if (it < 2) addr = C_ADDR;
         rw   = 1'($urandom_range(0, 1));
         n    = $urandom_range(1, 3);
         hit  = (addr == C_ADDR);
         bytes.delete();
         for (int k = 0; k <= n; k++) bytes.push_back(8'($urandom));
         rv0 = rxv_cnt; tl0 = txl_cnt; dn0 = done_cnt;
         bus.TxData = bytes[0];
         m_start();
         m_write_byte({addr, rw}, a);
         n_cmp++; if (a !== !hit) begin n_bad++; $display("FAIL rnd_addr_ack addr %h got %b want %b", addr, a, !hit); end
         for (int k = 0; k < n; k++) begin
            if (rw) begin
               bus.TxData = bytes[k + 1];
               ack_m = (k == n - 1);
               m_read_byte(ack_m, d);
               n_cmp++; if (d !== (hit ? bytes[k] : 8'hFF)) begin n_bad++; $display("FAIL rnd_read[%0d] got %h want %h", k, d, hit ? bytes[k] : 8'hFF); end
            end else begin
               m_write_byte(bytes[k], a);
               if (hit) model_rx = bytes[k];
               n_cmp++; if (a !== !hit) begin n_bad++; $display("FAIL rnd_data_ack[%0d] got %b want %b", k, a, !hit); end
            end
         end
         m_stop();
         n_cmp++; if (rxv_cnt - rv0 !== ((hit && !rw) ? n : 0)) begin n_bad++; $display("FAIL rnd_rxvalid got %0d want %0d", rxv_cnt - rv0, (hit && !rw) ? n : 0); end
         n_cmp++; if (txl_cnt - tl0 !== ((hit && rw) ? n : 0)) begin n_bad++; $display("FAIL rnd_txload got %0d want %0d", txl_cnt - tl0, (hit && rw) ? n : 0); end
         n_cmp++; if (done_cnt - dn0 !== (hit ? 1 : 0)) begin n_bad++; $display("FAIL rnd_done got %0d want %0d", done_cnt - dn0, hit ? 1 : 0); end
         n_cmp++; if (bus.RxData !== model_rx) begin n_bad++; $display("FAIL rnd_rxdata got %h want %h", bus.RxData, model_rx); end
      end
   endtask

   initial begin
      bus.EN     = 1'b1;
      bus.SCL    = 1'b1;
      bus.TxData = 8'h00;
      test_reset();
      test_write();
      test_wrong_addr();
      test_read_nack();
      test_two_byte_read();
      test_rep_start();
      test_reset_mid();
      test_enable();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
